// File: rtl/switch_debounce_pkg.sv
// Constants shared by the switch front end, the blink logic and their benches.
// Holds channel count, debounce lengths and the counter width helper.
package switch_debounce_pkg;

  localparam int N_SW_DEFAULT               = 4;
  localparam int DEBOUNCE_CYCLES_12MHZ_10MS = 120000;
  localparam int DEBOUNCE_CYCLES_SIM        = 4;

  // Width needed to hold 0..cycles; a count of 1 still gets a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: 2-flop synchroniser, disagreement counter, debounced level
// and press pulse; release pulse only when SW_RELEASE_PULSE_EN is defined.
module switch_debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_press
`ifdef SW_RELEASE_PULSE_EN
  ,
  output logic sw_release
`endif
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
`ifdef SW_RELEASE_PULSE_EN
  logic             release_q, release_d;
`endif

  always_comb begin
    s1_d     = sw_raw;
    s2_d     = s1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
`ifdef SW_RELEASE_PULSE_EN
    release_d = 1'b0;
`endif
    // Any agreement discards the running disagreement count.
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = s2_q;
      press_d  = s2_q;
`ifdef SW_RELEASE_PULSE_EN
      release_d = ~s2_q;
`endif
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
`ifdef SW_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
`ifdef SW_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  assign sw_stable  = stable_q;
  assign sw_press   = press_q;
`ifdef SW_RELEASE_PULSE_EN
  assign sw_release = release_q;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Push-button front end: N_SW independent debounce channels, wiring only.
// Define SW_RELEASE_PULSE_EN to add the sw_release pulse output.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ_10MS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_press
`ifdef SW_RELEASE_PULSE_EN
  ,
  output logic [N_SW-1:0] sw_release
`endif
);

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    switch_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (sw_raw[i]),
      .sw_stable (sw_stable[i]),
      .sw_press  (sw_press[i])
`ifdef SW_RELEASE_PULSE_EN
      ,
      .sw_release(sw_release[i])
`endif
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with a short debounce length; release pulse checked
// only when SW_RELEASE_PULSE_EN is defined.
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int NS = N_SW_DEFAULT;
  localparam int DC = DEBOUNCE_CYCLES_SIM;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] sw_raw;
  logic [NS-1:0] sw_stable;
  logic [NS-1:0] sw_press;
  logic [NS-1:0] rel_obs;
`ifdef SW_RELEASE_PULSE_EN
  logic [NS-1:0] sw_release;
  assign rel_obs = sw_release;
`else
  assign rel_obs = '0;
`endif

  always #5 clk = ~clk;

  switch_debounce #(.N_SW(NS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_press  (sw_press)
`ifdef SW_RELEASE_PULSE_EN
    ,
    .sw_release(sw_release)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: history of raw samples, one per edge. The value acted on at an edge is
  // the raw sampled two edges earlier; a channel flips when the last DC acted-on
  // samples all differ from its current level.
  logic [NS-1:0] hist[$];
  logic [NS-1:0] exp_stable, exp_press, exp_rel;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DC + 2; i++) hist.push_back('0);
    exp_stable = '0;
    exp_press  = '0;
    exp_rel    = '0;
  endtask

  task automatic tick(input logic [NS-1:0] raw);
    bit all_diff;
    sw_raw = raw;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(raw);
      exp_press = '0;
      exp_rel   = '0;
      for (int ch = 0; ch < NS; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++)
          if (hist[hist.size() - 3 - j][ch] == exp_stable[ch]) all_diff = 1'b0;
        if (all_diff) begin
          exp_stable[ch] = ~exp_stable[ch];
          if (exp_stable[ch]) exp_press[ch] = 1'b1;
          else                exp_rel[ch]   = 1'b1;
        end
      end
`ifndef SW_RELEASE_PULSE_EN
      exp_rel = '0;
`endif
      void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sw_raw = '1;
    model_reset();
    #3;
    total++;
    if ({sw_stable, sw_press, rel_obs} !== '0) begin
      bad++;
      $display("FAIL reset_immediate: got stable=%b press=%b rel=%b want all 0", sw_stable, sw_press, rel_obs);
    end
    for (int k = 0; k < 4; k++) begin
      tick('1);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== '0) begin
        bad++;
        $display("FAIL reset_held k=%0d: got stable=%b press=%b rel=%b want all 0", k, sw_stable, sw_press, rel_obs);
      end
    end
    tick('0);
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    int press_edge = -1;
    int press_cnt  = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(4'b0001);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL single_press k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      if (sw_press[0]) begin
        press_cnt++;
        if (press_edge < 0) press_edge = k;
      end
    end
    total++;
    if (press_edge != DC + 2 || press_cnt != 1) begin
      bad++;
      $display("FAIL single_press_latency: got edge=%0d count=%0d want edge=%0d count=1", press_edge, press_cnt, DC + 2);
    end
    for (int k = 0; k < 8; k++) begin
      tick('0);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL single_release k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
    end
  endtask

  task automatic test_short_glitch();
    logic seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(k < 3 ? 4'b0010 : 4'b0000);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL short_glitch k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      if (sw_stable[1] || sw_press[1]) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL short_glitch_ch1: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat = 9'b1_1111_0101;  // bit k is the level in tick k+1
    int press_tick = -1;
    int press_cnt  = 0;
    for (int k = 0; k < 16; k++) begin
      tick((k < 9 && !pat[k]) ? 4'b0000 : 4'b0100);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL bounce k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      if (sw_press[2]) begin
        press_cnt++;
        if (press_tick < 0) press_tick = k + 1;
      end
    end
    total++;
    if (press_cnt != 1 || press_tick != 5 + DC + 1) begin
      bad++;
      $display("FAIL bounce_press: got count=%0d tick=%0d want count=1 tick=%0d", press_cnt, press_tick, 5 + DC + 1);
    end
    for (int k = 0; k < 8; k++) tick('0);
  endtask

  task automatic test_simultaneous();
    int pulse_cycles = 0;
    logic [NS-1:0] pulse_val = '0;
    for (int k = 0; k < 9; k++) begin
      tick('1);
      if (sw_press != '0) begin
        pulse_cycles++;
        pulse_val = sw_press;
      end
    end
    total++;
    if (pulse_cycles != 1 || pulse_val !== 4'hF || sw_stable !== 4'hF) begin
      bad++;
      $display("FAIL simultaneous_press: got cycles=%0d press=%b stable=%b want 1/1111/1111", pulse_cycles, pulse_val, sw_stable);
    end
    pulse_cycles = 0;
    pulse_val    = '0;
    for (int k = 0; k < 9; k++) begin
      tick('0);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL simultaneous_release k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      if (sw_stable != '0 && sw_stable != '1) pulse_cycles = 99;
    end
    total++;
    if (pulse_cycles != 0 || sw_stable !== '0) begin
      bad++;
      $display("FAIL simultaneous_clear: got split=%0d stable=%b want 0/0000", pulse_cycles, sw_stable);
    end
  endtask

  task automatic test_reset_mid_count();
    int press_tick = -1;
    for (int k = 0; k < 8; k++) tick(4'b0001);
    tick(4'b1001);
    tick(4'b1001);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({sw_stable, sw_press, rel_obs} !== '0) begin
      bad++;
      $display("FAIL mid_count_reset: got stable=%b press=%b rel=%b want all 0", sw_stable, sw_press, rel_obs);
    end
    tick(4'b1001);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(4'b1001);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL after_reset k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      if (sw_press[3] && press_tick < 0) press_tick = k;
    end
    total++;
    if (press_tick != DC + 2) begin
      bad++;
      $display("FAIL after_reset_latency: got tick=%0d want %0d", press_tick, DC + 2);
    end
    for (int k = 0; k < 8; k++) tick('0);
  endtask

  task automatic test_random();
    logic [NS-1:0] raw = '0;
    for (int k = 0; k < 400; k++) begin
      if ((k % 50) < 40)
        for (int b = 0; b < NS; b++)
          if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
      tick(raw);
      total++;
      if ({sw_stable, sw_press, rel_obs} !== {exp_stable, exp_press, exp_rel}) begin
        bad++;
        $display("FAIL random k=%0d: got %b/%b/%b want %b/%b/%b", k, sw_stable, sw_press, rel_obs, exp_stable, exp_press, exp_rel);
      end
      total++;
      if ((sw_press & rel_obs) !== '0) begin
        bad++;
        $display("FAIL random_both_pulses k=%0d: got press=%b rel=%b want no overlap", k, sw_press, rel_obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_short_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
